// File: rtl/mem_periph_bus.sv
// mem_periph_bus: memory-mapped peripheral responder at the far end of the MEM
// stage. Holds the timer (TH/TL/TCON), LED, switch, 7-segment and system tick
// registers, answers word loads/stores inside a 32-byte window at BASE_ADDR and
// raises a level timer interrupt toward the PC-select / flush logic.
module mem_periph_bus #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000  // bits [4:0] must be 0
) (
   input  logic        CLK,
   input  logic        Reset_n,
   input  logic        MEM_MemRd,
   input  logic        MEM_MemWr,
   input  logic [31:0] MEM_Addr,
   input  logic [31:0] MEM_WriteData,
   output logic [31:0] MEM_ReadData,
   input  logic [7:0]  switch,
   output logic [7:0]  led,
   output logic [11:0] digi,
   output logic        irqout
);

   // Register offsets inside the window (word index, MEM_Addr[4:2]).
   localparam logic [2:0] OFF_TH      = 3'd0;
   localparam logic [2:0] OFF_TL      = 3'd1;
   localparam logic [2:0] OFF_TCON    = 3'd2;
   localparam logic [2:0] OFF_LED     = 3'd3;
   localparam logic [2:0] OFF_SWITCH  = 3'd4;
   localparam logic [2:0] OFF_DIGI    = 3'd5;
   localparam logic [2:0] OFF_SYSTICK = 3'd6;

   // TCON bit positions.
   localparam int TCON_EN   = 0;
   localparam int TCON_IE   = 1;
   localparam int TCON_STAT = 2;

   logic [31:0] th;
   logic [31:0] tl;
   logic [2:0]  tcon;
   logic [31:0] systick;
   logic [7:0]  sw_s1;
   logic [7:0]  sw_s2;

   logic        hit;
   logic [2:0]  offset;
   logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
   logic        tl_max;
   logic        overflow;
   logic [31:0] rd_word;

   // Byte lane bits are ignored: the window is word-access only.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^MEM_Addr[1:0];

   assign hit      = (MEM_Addr[31:5] == BASE_ADDR[31:5]);
   assign offset   = MEM_Addr[4:2];
   assign tl_max   = (tl == 32'hFFFF_FFFF);
   assign overflow = tcon[TCON_EN] && tl_max;

   // Per-register write strobes; RO/reserved offsets simply have no strobe.
   always_comb begin
      wr_th   = 1'b0;
      wr_tl   = 1'b0;
      wr_tcon = 1'b0;
      wr_led  = 1'b0;
      wr_digi = 1'b0;
      if (MEM_MemWr && hit) begin
         case (offset)
            OFF_TH:   wr_th   = 1'b1;
            OFF_TL:   wr_tl   = 1'b1;
            OFF_TCON: wr_tcon = 1'b1;
            OFF_LED:  wr_led  = 1'b1;
            OFF_DIGI: wr_digi = 1'b1;
            default:  ;
         endcase
      end
   end

   // TH reload value: plain CPU-written register.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n)   th <= '0;
      else if (wr_th) th <= MEM_WriteData;
   end

   // TL counter: a CPU write beats both the increment and the reload.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n)            tl <= '0;
      else if (wr_tl)          tl <= MEM_WriteData;
      else if (overflow)       tl <= th;
      else if (tcon[TCON_EN])  tl <= tl + 32'd1;
   end

   // TCON: a CPU write beats the overflow status set, so that status is lost.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n)                           tcon <= '0;
      else if (wr_tcon)                       tcon <= MEM_WriteData[2:0];
      else if (overflow && tcon[TCON_IE])     tcon[TCON_STAT] <= 1'b1;
   end

   // LED and 7-segment output registers, truncated from the store data.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         led  <= '0;
         digi <= '0;
      end else begin
         if (wr_led)  led  <= MEM_WriteData[7:0];
         if (wr_digi) digi <= MEM_WriteData[11:0];
      end
   end

   // Free-running tick counter; wraps naturally at 2^32.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) systick <= '0;
      else          systick <= systick + 32'd1;
   end

   // Two-flop synchronizer for the asynchronous board switches.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         sw_s1 <= switch;
         sw_s2 <= sw_s1;
      end
   end

   // Combinational read mux; a simultaneous store shows only after the edge.
   always_comb begin
      rd_word = '0;
      case (offset)
         OFF_TH:      rd_word = th;
         OFF_TL:      rd_word = tl;
         OFF_TCON:    rd_word = {29'd0, tcon};
         OFF_LED:     rd_word = {24'd0, led};
         OFF_SWITCH:  rd_word = {24'd0, sw_s2};
         OFF_DIGI:    rd_word = {20'd0, digi};
         OFF_SYSTICK: rd_word = systick;
         default:     rd_word = '0;
      endcase
      MEM_ReadData = (MEM_MemRd && hit) ? rd_word : 32'd0;
   end

   assign irqout = tcon[TCON_IE] & tcon[TCON_STAT];

endmodule

// File: tb/tb_mem_periph_bus.sv
// Testbench for mem_periph_bus: reference model plus expected-value queue.
module tb_mem_periph_bus;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        CLK;
   logic        Reset_n;
   logic        MEM_MemRd;
   logic        MEM_MemWr;
   logic [31:0] MEM_Addr;
   logic [31:0] MEM_WriteData;
   logic [31:0] MEM_ReadData;
   logic [7:0]  switch;
   logic [7:0]  led;
   logic [11:0] digi;
   logic        irqout;

   mem_periph_bus #(.BASE_ADDR(BASE)) dut (
      .CLK(CLK), .Reset_n(Reset_n),
      .MEM_MemRd(MEM_MemRd), .MEM_MemWr(MEM_MemWr),
      .MEM_Addr(MEM_Addr), .MEM_WriteData(MEM_WriteData),
      .MEM_ReadData(MEM_ReadData),
      .switch(switch), .led(led), .digi(digi), .irqout(irqout)
   );

   // Clock: rising edges at 5, 15, 25, ...
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] exp_q[$];

   // Reference model state
   logic [31:0] m_th, m_tl, m_tick;
   logic [2:0]  m_tcon;
   logic [7:0]  m_led, m_sw1, m_sw2;
   logic [11:0] m_digi;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_th = 0; m_tl = 0; m_tick = 0; m_tcon = 0;
      m_led = 0; m_sw1 = 0; m_sw2 = 0; m_digi = 0;
   endtask

   function automatic logic m_hit(input logic [31:0] a);
      return (a >> 5) == (BASE >> 5);
   endfunction

   function automatic logic [31:0] m_read(input logic rd, input logic [31:0] a);
      logic [2:0] o;
      o = a[4:2];
      if (!rd || !m_hit(a)) return 32'd0;
      case (o)
         3'd0: return m_th;
         3'd1: return m_tl;
         3'd2: return {29'd0, m_tcon};
         3'd3: return {24'd0, m_led};
         3'd4: return {24'd0, m_sw2};
         3'd5: return {20'd0, m_digi};
         3'd6: return m_tick;
         default: return 32'd0;
      endcase
   endfunction

   // Advance the model by one rising edge, using pre-edge values throughout.
   task automatic model_step(input logic wr, input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] n_th, n_tl;
      logic [2:0]  n_tcon, o;
      logic [7:0]  n_led;
      logic [11:0] n_digi;
      if (Reset_n) begin
         n_th = m_th; n_tl = m_tl; n_tcon = m_tcon; n_led = m_led; n_digi = m_digi;
         if (m_tcon[0]) begin
            if (m_tl == 32'hFFFF_FFFF) begin
               n_tl = m_th;
               if (m_tcon[1]) n_tcon[2] = 1'b1;
            end else begin
               n_tl = m_tl + 1;
            end
         end
         o = a[4:2];
         if (wr && m_hit(a)) begin
            case (o)
               3'd0: n_th = wd;
               3'd1: n_tl = wd;
               3'd2: n_tcon = wd[2:0];
               3'd3: n_led = wd[7:0];
               3'd5: n_digi = wd[11:0];
               default: ;
            endcase
         end
         m_th = n_th; m_tl = n_tl; m_tcon = n_tcon; m_led = n_led; m_digi = n_digi;
         m_sw2 = m_sw1; m_sw1 = switch;
         m_tick = m_tick + 1;
      end
   endtask

   // One bus cycle, entered and left at a falling edge. Expected read data is
   // queued when stimulus is applied and popped when the DUT output is sampled.
   task automatic bus(input string tag, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit use_const = 1'b0, input logic [31:0] cexp = 32'd0);
      MEM_MemRd = rd; MEM_MemWr = wr; MEM_Addr = a; MEM_WriteData = wd;
      exp_q.push_back(use_const ? cexp : m_read(rd, a));
      #1;
      check({tag, "_rd"}, MEM_ReadData, exp_q.pop_front());
      check({tag, "_irq"}, {31'd0, irqout}, {31'd0, m_tcon[1] & m_tcon[2]});
      check({tag, "_led"}, {24'd0, led}, {24'd0, m_led});
      check({tag, "_digi"}, {20'd0, digi}, {20'd0, m_digi});
      @(posedge CLK);
      model_step(wr, a, wd);
      @(negedge CLK);
      MEM_MemRd = 0; MEM_MemWr = 0;
   endtask

   function automatic logic [31:0] ra(input int off);
      return BASE + 32'(off * 4);
   endfunction

   initial begin
      Reset_n = 1'b0; MEM_MemRd = 0; MEM_MemWr = 0; MEM_Addr = 0; MEM_WriteData = 0;
      switch = 8'h00;
      model_reset();
      @(negedge CLK);

      // Reads under reset: everything zero
      for (int i = 0; i < 8; i++) bus("rst_read", 1, 0, ra(i), 0, 1, 32'd0);
      Reset_n = 1'b1;

      // LED / DIGI
      bus("wr_led", 0, 1, ra(3), 32'h1234_56A5);
      check("led_a5", {24'd0, led}, 32'h0000_00A5);
      bus("rd_led", 1, 0, ra(3), 0, 1, 32'h0000_00A5);
      bus("wr_digi", 0, 1, ra(5), 32'hFFFF_FFFF);
      check("digi_fff", {20'd0, digi}, 32'h0000_0FFF);
      bus("rd_digi", 1, 0, ra(5), 0, 1, 32'h0000_0FFF);
      bus("rd_tick", 1, 0, ra(6), 0);

      // Timer overflow and interrupt
      bus("wr_th", 0, 1, ra(0), 32'hFFFF_FFFC);
      bus("wr_tl", 0, 1, ra(1), 32'hFFFF_FFFE);
      bus("wr_tcon", 0, 1, ra(2), 32'h0000_0003);
      bus("tl_fffe", 1, 0, ra(1), 0, 1, 32'hFFFF_FFFE);
      bus("tl_ffff", 1, 0, ra(1), 0, 1, 32'hFFFF_FFFF);
      check("irq_rise", {31'd0, irqout}, 32'd1);
      bus("tl_reload", 1, 0, ra(1), 0, 1, 32'hFFFF_FFFC);
      bus("clr_stat", 0, 1, ra(2), 32'h0000_0003);
      check("irq_fall", {31'd0, irqout}, 32'd0);
      bus("tcon_3", 1, 0, ra(2), 0, 1, 32'h0000_0003);

      // Overflow coincident with a TCON write of 1: status lost
      bus("stop", 0, 1, ra(2), 32'h0);
      bus("wr_tl2", 0, 1, ra(1), 32'hFFFF_FFFD);
      bus("start", 0, 1, ra(2), 32'h0000_0003);
      bus("tl_fffd", 1, 0, ra(1), 0, 1, 32'hFFFF_FFFD);
      bus("tl_fffe2", 1, 0, ra(1), 0, 1, 32'hFFFF_FFFE);
      bus("ovf_wr", 0, 1, ra(2), 32'h0000_0001);
      check("irq_lost", {31'd0, irqout}, 32'd0);
      bus("tl_rel2", 1, 0, ra(1), 0, 1, 32'hFFFF_FFFC);
      bus("tcon_1", 1, 0, ra(2), 0, 1, 32'h0000_0001);

      // Disabled timer holds
      bus("dis", 0, 1, ra(2), 32'h0);
      bus("hold_a", 1, 0, ra(1), 0);
      bus("hold_b", 1, 0, ra(1), 0);

      // Ignored stores, misses, read gating, read-before-write
      bus("wr_sw", 0, 1, ra(4), 32'hFFFF_FFFF);
      bus("wr_miss", 0, 1, 32'h5000_000C, 32'h0000_0077);
      bus("led_keep", 1, 0, ra(3), 0, 1, 32'h0000_00A5);
      bus("sw_keep", 1, 0, ra(4), 0, 1, 32'h0);
      bus("rd_miss", 1, 0, 32'h5000_000C, 0, 1, 32'h0);
      bus("no_rd", 0, 0, ra(3), 0, 1, 32'h0);
      bus("rd_resv", 1, 0, ra(7), 0, 1, 32'h0);
      bus("rdwr", 1, 1, ra(3), 32'h0000_005A, 1, 32'h0000_00A5);
      bus("rd_5a", 1, 0, ra(3), 0, 1, 32'h0000_005A);

      // Switch synchronizer latency
      switch = 8'h3C;
      bus("sw_n", 1, 0, ra(4), 0, 1, 32'h0);
      bus("sw_n1", 1, 0, ra(4), 0, 1, 32'h0);
      bus("sw_n2", 1, 0, ra(4), 0, 1, 32'h0000_003C);

      // Asynchronous reset in the middle of a count
      bus("run", 0, 1, ra(2), 32'h0000_0003);
      bus("run_a", 1, 0, ra(1), 0);
      bus("run_b", 1, 0, ra(6), 0);
      Reset_n = 1'b0;
      model_reset();
      #1;
      check("rst_led", {24'd0, led}, 32'h0);
      check("rst_irq", {31'd0, irqout}, 32'h0);
      @(negedge CLK);
      Reset_n = 1'b1;
      bus("tick0", 1, 0, ra(6), 0, 1, 32'd0);
      bus("tl0", 1, 0, ra(1), 0, 1, 32'd0);
      bus("tcon0", 1, 0, ra(2), 0, 1, 32'd0);
      bus("tick3", 1, 0, ra(6), 0, 1, 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
